// File: rtl/vector_mac_pipe.sv
// rtl/vector_mac_pipe.sv - pipelined LANES-wide multiplier with elementwise and dot-accumulate modes; optional macro VMUL_SIGNED_EN
module vector_mac_pipe #(
  parameter int LANES     = 4,
  parameter int WIDTH     = 8,
  parameter int ACC_WIDTH = 2*WIDTH+8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [LANES*WIDTH-1:0]   in_a,
  input  logic [LANES*WIDTH-1:0]   in_b,
  input  logic                     in_mode,
  input  logic                     in_last,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [LANES*2*WIDTH-1:0] out_prod,
  output logic [ACC_WIDTH-1:0]     out_dot,
  output logic                     out_mode,
  output logic [7:0]               out_beats
);

  localparam int PW = 2*WIDTH;

  logic                 stall;
  logic [LANES*PW-1:0]  mul_prod;
  logic [LANES*PW-1:0]  s1_prod;
  logic                 s1_valid;
  logic                 s1_mode;
  logic                 s1_last;
  logic [ACC_WIDTH-1:0] acc;
  logic [ACC_WIDTH-1:0] lane_sum;
  logic [7:0]           beat_cnt;
  logic [7:0]           beat_inc;

  // A presented result that is not taken freezes the whole pipe
  assign stall    = out_valid && !out_ready;
  assign in_ready = !stall;

  // Full-width product of every lane for the beat on the input port
  always_comb begin
    mul_prod = '0;
    for (int i = 0; i < LANES; i++) begin
`ifdef VMUL_SIGNED_EN
      mul_prod[i*PW +: PW] = PW'($signed(in_a[i*WIDTH +: WIDTH])) *
                             PW'($signed(in_b[i*WIDTH +: WIDTH]));
`else
      mul_prod[i*PW +: PW] = PW'(in_a[i*WIDTH +: WIDTH]) *
                             PW'(in_b[i*WIDTH +: WIDTH]);
`endif
    end
  end

  // Sum of the registered lane products, extended to accumulator width
  always_comb begin
    lane_sum = '0;
    for (int i = 0; i < LANES; i++) begin
`ifdef VMUL_SIGNED_EN
      lane_sum = lane_sum + ACC_WIDTH'($signed(s1_prod[i*PW +: PW]));
`else
      lane_sum = lane_sum + ACC_WIDTH'(s1_prod[i*PW +: PW]);
`endif
    end
  end

  // Beat counter advance, sticking at 255
  assign beat_inc = (beat_cnt == 8'hFF) ? 8'hFF : beat_cnt + 8'd1;

  // Stage 1: capture products and beat attributes unless stalled
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_mode  <= 1'b0;
      s1_last  <= 1'b0;
      s1_prod  <= '0;
    end else if (!stall) begin
      s1_valid <= in_valid;
      s1_mode  <= in_mode;
      s1_last  <= in_last;
      s1_prod  <= mul_prod;
    end
  end

  // Stage 2: present elementwise results, accumulate dot beats, emit on last
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_prod  <= '0;
      out_dot   <= '0;
      out_mode  <= 1'b0;
      out_beats <= 8'd0;
      acc       <= '0;
      beat_cnt  <= 8'd0;
    end else if (!stall) begin
      out_valid <= 1'b0;
      if (s1_valid) begin
        if (!s1_mode) begin
          out_valid <= 1'b1;
          out_prod  <= s1_prod;
          out_mode  <= 1'b0;
        end else if (s1_last) begin
          out_valid <= 1'b1;
          out_prod  <= s1_prod;
          out_mode  <= 1'b1;
          out_dot   <= acc + lane_sum;
          out_beats <= beat_inc;
          acc       <= '0;
          beat_cnt  <= 8'd0;
        end else begin
          acc       <= acc + lane_sum;
          beat_cnt  <= beat_inc;
        end
      end
    end
  end

endmodule

// File: tb/tb_vector_mac_pipe.sv
// tb/tb_vector_mac_pipe.sv - self-checking bench for vector_mac_pipe
module tb_vector_mac_pipe;

  localparam int LANES     = 4;
  localparam int WIDTH     = 8;
  localparam int ACC_WIDTH = 2*WIDTH+8;
  localparam int PW        = 2*WIDTH;
  localparam int VW        = LANES*WIDTH;
  localparam int PV        = LANES*PW;

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b0;
  logic                 in_valid = 1'b0;
  logic                 in_ready;
  logic [VW-1:0]        in_a = '0;
  logic [VW-1:0]        in_b = '0;
  logic                 in_mode = 1'b0;
  logic                 in_last = 1'b0;
  logic                 out_valid;
  logic                 out_ready = 1'b1;
  logic [PV-1:0]        out_prod;
  logic [ACC_WIDTH-1:0] out_dot;
  logic                 out_mode;
  logic [7:0]           out_beats;

  vector_mac_pipe #(.LANES(LANES), .WIDTH(WIDTH), .ACC_WIDTH(ACC_WIDTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
    .in_mode(in_mode), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready), .out_prod(out_prod),
    .out_dot(out_dot), .out_mode(out_mode), .out_beats(out_beats)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [PV-1:0]        prod;
    logic [ACC_WIDTH-1:0] dot;
    logic                 mode;
    logic [7:0]           beats;
  } exp_t;

  typedef struct {
    logic [VW-1:0]        a;
    logic [VW-1:0]        b;
    logic                 mode;
    logic                 last;
    logic                 has_out;
    logic [PV-1:0]        prod;
    logic [ACC_WIDTH-1:0] dot;
    logic [7:0]           beats;
  } vec_t;

  exp_t   exp_q[$];
  vec_t   tab[$];
  int     n_checks = 0;
  int     n_fail   = 0;
  longint m_acc    = 0;
  int     m_cnt    = 0;
  bit     use_model = 1'b0;
  exp_t   pending;
  bit     pending_has = 1'b0;
  bit     rand_on = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic longint lane_of(input logic [VW-1:0] v, input int i);
    logic [WIDTH-1:0] x;
    x = v[i*WIDTH +: WIDTH];
`ifdef VMUL_SIGNED_EN
    return longint'($signed(x));
`else
    return longint'(x);
`endif
  endfunction

  // Reference: products as plain integers, dot results as a running sum
  task automatic model_beat(input logic [VW-1:0] a, input logic [VW-1:0] b,
                            input logic mode, input logic last);
    exp_t   e;
    longint p;
    longint s;
    s = 0;
    e.prod = '0; e.dot = '0; e.beats = '0; e.mode = mode;
    for (int i = 0; i < LANES; i++) begin
      p = lane_of(a, i) * lane_of(b, i);
      e.prod[i*PW +: PW] = p[PW-1:0];
      s += p;
    end
    if (!mode) exp_q.push_back(e);
    else begin
      m_acc += s;
      m_cnt++;
      if (last) begin
        e.dot   = m_acc[ACC_WIDTH-1:0];
        e.beats = (m_cnt > 255) ? 8'd255 : 8'(m_cnt);
        exp_q.push_back(e);
        m_acc = 0;
        m_cnt = 0;
      end
    end
  endtask

  // Drives one beat starting at negedge+1, returns at negedge+1 after acceptance
  task automatic send_beat(input logic [VW-1:0] a, input logic [VW-1:0] b,
                           input logic mode, input logic last);
    int waited;
    bit done;
    waited = 0;
    done = 1'b0;
    in_valid = 1'b1; in_a = a; in_b = b; in_mode = mode; in_last = last;
    while (!done) begin
      #2;
      if (in_ready) begin
        if (use_model) model_beat(a, b, mode, last);
        else if (pending_has) exp_q.push_back(pending);
        done = 1'b1;
      end else if (++waited > 50) begin
        check("in_ready_timeout", 64'(in_ready), 64'd1);
        done = 1'b1;
      end
      @(negedge clk); #1;
    end
  endtask

  task automatic idle_cycles(input int n);
    in_valid = 1'b0;
    repeat (n) begin @(negedge clk); #1; end
  endtask

  function automatic vec_t mk(input logic [VW-1:0] a, input logic [VW-1:0] b, input logic mode,
                              input logic last, input logic has_out, input logic [PV-1:0] prod,
                              input logic [ACC_WIDTH-1:0] dot, input logic [7:0] beats);
    vec_t v;
    v = '{a, b, mode, last, has_out, prod, dot, beats};
    return v;
  endfunction

  // Monitor: retire results against the scoreboard, check stall behaviour
  logic          prev_stall = 1'b0;
  logic [PV-1:0] prev_prod;
  logic [ACC_WIDTH-1:0] prev_dot;
  logic          prev_mode;
  logic [7:0]    prev_beats;
  always @(negedge clk) begin
    exp_t e;
    #3;
    if (!rst_n) prev_stall = 1'b0;
    else begin
      if (prev_stall) begin
        check("stall_valid_hold", 64'(out_valid), 64'd1);
        check("stall_prod_hold", 64'(out_prod), 64'(prev_prod));
        check("stall_dot_hold", 64'(out_dot), 64'(prev_dot));
        check("stall_mode_hold", 64'(out_mode), 64'(prev_mode));
        check("stall_beats_hold", 64'(out_beats), 64'(prev_beats));
      end
      check("in_ready_rule", 64'(in_ready), 64'(!(out_valid && !out_ready)));
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) check("unexpected_result", 64'(out_valid), 64'd0);
        else begin
          e = exp_q.pop_front();
          check("out_prod", 64'(out_prod), 64'(e.prod));
          check("out_mode", 64'(out_mode), 64'(e.mode));
          if (e.mode) begin
            check("out_dot", 64'(out_dot), 64'(e.dot));
            check("out_beats", 64'(out_beats), 64'(e.beats));
          end
        end
      end
      prev_stall = out_valid && !out_ready;
      prev_prod = out_prod; prev_dot = out_dot; prev_mode = out_mode; prev_beats = out_beats;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    int lat;
    logic [VW-1:0] ra, rb;
    logic rm, rl;

    // Reset state
    #12;
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out_prod", 64'(out_prod), 64'd0);
    check("rst_out_dot", 64'(out_dot), 64'd0);
    check("rst_out_mode", 64'(out_mode), 64'd0);
    check("rst_out_beats", 64'(out_beats), 64'd0);
    @(negedge clk); rst_n = 1'b1; #1;
    check("rst_in_ready", 64'(in_ready), 64'd1);

    // Latency and single-cycle out_valid for one elementwise beat
    use_model = 1'b1;
    send_beat(32'h08060402, 32'h09070503, 1'b0, 1'b0);
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 6) begin @(negedge clk); #1; lat++; end
    check("latency_edges", 64'(lat), 64'd2);
    @(negedge clk); #1;
    check("out_valid_one_cycle", 64'(out_valid), 64'd0);
    idle_cycles(2);

    // Directed vector table with hand-derived results
    use_model = 1'b0;
`ifdef VMUL_SIGNED_EN
    tab.push_back(mk(32'hFEFEFEFE, 32'h03030303, 0, 0, 1, 64'hFFFA_FFFA_FFFA_FFFA, 0, 0));
    tab.push_back(mk(32'hFEFEFEFE, 32'h03030303, 1, 1, 1, 64'hFFFA_FFFA_FFFA_FFFA, 24'hFFFFE8, 1));
`else
    tab.push_back(mk(32'h08060402, 32'h09070503, 0, 0, 1, 64'h0048_002A_0014_0006, 0, 0));
    tab.push_back(mk(32'h08060402, 32'h09070503, 1, 1, 1, 64'h0048_002A_0014_0006, 24'd140, 1));
    tab.push_back(mk(32'h01010101, 32'h01010101, 1, 1, 1, 64'h0001_0001_0001_0001, 24'd4, 1));
    tab.push_back(mk(32'hFFFFFFFF, 32'hFFFFFFFF, 1, 0, 0, 0, 0, 0));
    tab.push_back(mk(32'hFFFFFFFF, 32'hFFFFFFFF, 1, 0, 0, 0, 0, 0));
    tab.push_back(mk(32'hFFFFFFFF, 32'hFFFFFFFF, 1, 1, 1, 64'hFE01_FE01_FE01_FE01, 24'd780300, 3));
    tab.push_back(mk(32'h08060402, 32'h09070503, 1, 0, 0, 0, 0, 0));
    tab.push_back(mk(32'h01010101, 32'h07070707, 0, 0, 1, 64'h0007_0007_0007_0007, 0, 0));
    tab.push_back(mk(32'h01010101, 32'h01010101, 1, 1, 1, 64'h0001_0001_0001_0001, 24'd144, 2));
`endif
    foreach (tab[k]) begin
      pending = '{tab[k].prod, tab[k].dot, tab[k].mode, tab[k].beats};
      pending_has = tab[k].has_out;
      send_beat(tab[k].a, tab[k].b, tab[k].mode, tab[k].last);
    end
    idle_cycles(4);
    check("table_drained", 64'(exp_q.size()), 64'd0);

    // Back-pressure: four elementwise beats, consumer stalls five cycles
    use_model = 1'b1;
    fork
      begin
        for (int k = 0; k < 4; k++)
          send_beat(VW'($urandom), VW'($urandom), 1'b0, 1'b0);
        in_valid = 1'b0;
      end
      begin
        int w;
        w = 0;
        while (!out_valid && w < 20) begin @(negedge clk); #1; w++; end
        check("bp_first_result_seen", 64'(out_valid), 64'd1);
        out_ready = 1'b0;
        repeat (5) begin
          @(negedge clk); #1;
          check("bp_in_ready_low", 64'(in_ready), 64'd0);
        end
        out_ready = 1'b1;
      end
    join
    idle_cycles(5);
    check("bp_all_delivered", 64'(exp_q.size()), 64'd0);

    // Reset in the middle of an accumulation discards it
    send_beat(32'h08060402, 32'h09070503, 1'b1, 1'b0);
    send_beat(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 1'b0);
    in_valid = 1'b0;
    rst_n = 1'b0;
    m_acc = 0; m_cnt = 0;
    exp_q.delete();
    #1;
    check("midrst_out_valid", 64'(out_valid), 64'd0);
    check("midrst_out_dot", 64'(out_dot), 64'd0);
    check("midrst_out_beats", 64'(out_beats), 64'd0);
    @(negedge clk); @(negedge clk); rst_n = 1'b1; #1;
    use_model = 1'b0;
    pending = '{64'h0001_0001_0001_0001, 24'd4, 1'b1, 8'd1};
    pending_has = 1'b1;
    send_beat(32'h01010101, 32'h01010101, 1'b1, 1'b1);
    idle_cycles(4);
    check("midrst_drained", 64'(exp_q.size()), 64'd0);

    // Randomised traffic with random back-pressure against the model
    use_model = 1'b1;
    rand_on = 1'b1;
    fork
      begin
        while (rand_on) begin
          @(negedge clk); #1;
          out_ready = ($urandom_range(3) != 0);
        end
        out_ready = 1'b1;
      end
      begin
        for (int k = 0; k < 300; k++) begin
          ra = VW'($urandom); rb = VW'($urandom);
          rm = 1'($urandom_range(1));
          rl = ($urandom_range(3) == 0);
          send_beat(ra, rb, rm, rl);
          if ($urandom_range(7) == 0) idle_cycles(1);
        end
        send_beat(VW'($urandom), VW'($urandom), 1'b1, 1'b1);
        in_valid = 1'b0;
        rand_on = 1'b0;
      end
    join
    idle_cycles(8);
    check("random_drained", 64'(exp_q.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
